sine_level_encoder: RTL and testbench



---
 rtl/sine_pkg.sv | 33 +++
 rtl/sine_therm_popcount.sv | 16 +
 rtl/sine_level_encoder.sv | 115 +++++++++++
 tb/tb_sine_level_encoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared widths, limits and thermometer helpers for the sine level encoder.
// Optional build macro used by the encoder: SINE_LEVEL_BUBBLE_FIX_EN.
package sine_pkg;
  localparam int WORD_W  = 33;
  localparam int THERM_W = 31;
  localparam int LSB_W   = 2;
  localparam int LEVEL_W = 7;
  localparam int ERR_W   = 8;

  localparam logic [ERR_W-1:0]   ERR_MAX   = 8'd255;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 7'd127;

  // A bubble is any set bit sitting directly above a clear bit.
  function automatic logic therm_bubble(input logic [THERM_W-1:0] f);
    logic b;
    b = 1'b0;
    for (int i = 1; i < THERM_W; i++) begin
      b = b | (f[i] & ~f[i-1]);
    end
    return b;
  endfunction

  // Majority-of-3 smoothing; a 1 is assumed below the field and a 0 above it.
  function automatic logic [THERM_W-1:0] therm_maj3(input logic [THERM_W-1:0] f);
    logic [THERM_W+1:0] t;
    logic [THERM_W-1:0] c;
    t = {1'b0, f, 1'b1};
    for (int i = 0; i < THERM_W; i++) begin
      c[i] = (t[i] & t[i+1]) | (t[i] & t[i+2]) | (t[i+1] & t[i+2]);
    end
    return c;
  endfunction
endpackage

// File: rtl/sine_therm_popcount.sv
// Combinational ones-count of the 31-bit thermometer field.
module sine_therm_popcount
  import sine_pkg::*;
(
  input  logic [THERM_W-1:0] i_therm,
  output logic [4:0]         o_count
);

  always_comb begin
    o_count = 5'd0;
    for (int i = 0; i < THERM_W; i++) begin
      o_count = o_count + {4'd0, i_therm[i]};
    end
  end

endmodule

// File: rtl/sine_level_encoder.sv
// Recovers the 7-bit level from the segmented DAC word through a two-stage
// valid/ready pipeline. SINE_LEVEL_BUBBLE_FIX_EN enables majority smoothing.
module sine_level_encoder
  import sine_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] out_level,
  output logic               out_bubble,
  input  logic               err_clr,
  output logic [ERR_W-1:0]   err_cnt,
  input  logic               pk_clr,
  output logic [LEVEL_W-1:0] pk_level
);

  logic               r_s1_valid;
  logic [THERM_W-1:0] r_s1_field;
  logic [LSB_W-1:0]   r_s1_lsb;
  logic               r_s1_bubble;
  logic               r_s2_valid;
  logic [LEVEL_W-1:0] r_s2_level;
  logic               r_s2_bubble;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [LEVEL_W-1:0] r_pk_level;

  logic               w_s2_load;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic [THERM_W-1:0] w_in_field;
  logic [THERM_W-1:0] w_s1_field_d;
  logic               w_in_bubble;
  logic [4:0]         w_pop;

  assign w_s2_load   = ~r_s2_valid | out_ready;
  assign in_ready    = ~r_s1_valid | w_s2_load;
  assign w_in_xfer   = in_valid & in_ready;
  assign w_out_xfer  = r_s2_valid & out_ready;
  assign w_in_field  = in_word[WORD_W-1:LSB_W];
  assign w_in_bubble = therm_bubble(w_in_field);

`ifdef SINE_LEVEL_BUBBLE_FIX_EN
  assign w_s1_field_d = therm_maj3(w_in_field);
`else
  assign w_s1_field_d = w_in_field;
`endif

  sine_therm_popcount u_popcount (
    .i_therm (r_s1_field),
    .o_count (w_pop)
  );

  // Stage 1: capture the (optionally smoothed) field and the raw bubble flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_field  <= '0;
      r_s1_lsb    <= '0;
      r_s1_bubble <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_valid  <= 1'b1;
      r_s1_field  <= w_s1_field_d;
      r_s1_lsb    <= in_word[LSB_W-1:0];
      r_s1_bubble <= w_in_bubble;
    end else if (w_s2_load) begin
      r_s1_valid  <= 1'b0;
    end
  end

  // Stage 2: level = 4*popcount + LSBs; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_level  <= '0;
      r_s2_bubble <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_level  <= {w_pop, r_s1_lsb};
        r_s2_bubble <= r_s1_bubble;
      end
    end
  end

  // Saturating bubble counter; a clear in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_err_cnt <= '0;
    end else if (w_in_xfer && w_in_bubble && (r_err_cnt != ERR_MAX)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  // Peak hold of transferred levels; a clear restarts from the current transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pk_level <= '0;
    end else if (pk_clr) begin
      r_pk_level <= w_out_xfer ? r_s2_level : '0;
    end else if (w_out_xfer && (r_s2_level > r_pk_level)) begin
      r_pk_level <= r_s2_level;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_level  = r_s2_level;
  assign out_bubble = r_s2_bubble;
  assign err_cnt    = r_err_cnt;
  assign pk_level   = r_pk_level;

endmodule

// File: tb/tb_sine_level_encoder.sv
// Directed and randomized checks of sine_level_encoder against a queue-based
// reference model computing levels, bubbles, latency, counters and peak.
module tb_sine_level_encoder;
  import sine_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] in_word = 33'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  out_level;
  logic        out_bubble;
  logic        err_clr = 1'b0;
  logic [7:0]  err_cnt;
  logic        pk_clr = 1'b0;
  logic [6:0]  pk_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_err = 0;
  int m_pk = 0;
  logic last_acc = 1'b0;

  typedef struct {
    int level;
    int bubble;
    int t_acc;
  } exp_t;
  exp_t q[$];

  sine_level_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_level  (out_level),
    .out_bubble (out_bubble),
    .err_clr    (err_clr),
    .err_cnt    (err_cnt),
    .pk_clr     (pk_clr),
    .pk_level   (pk_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_bubble(input logic [32:0] w);
    for (int i = 3; i <= 32; i++) begin
      if (w[i] && !w[i-1]) return 1;
    end
    return 0;
  endfunction

  function automatic int ref_level(input logic [32:0] w);
    int n;
    n = 0;
`ifdef SINE_LEVEL_BUBBLE_FIX_EN
    begin
      int t[34];
      t[1] = 1;
      t[33] = 0;
      for (int k = 2; k <= 32; k++) t[k] = int'(w[k]);
      for (int k = 2; k <= 32; k++) if (t[k-1] + t[k] + t[k+1] >= 2) n++;
    end
`else
    for (int k = 2; k <= 32; k++) n += int'(w[k]);
`endif
    return 4 * n + int'(w[1:0]);
  endfunction

  function automatic logic front_presented();
    return (q.size() > 0) && (cyc - q[0].t_acc >= 2);
  endfunction

  // One clock cycle: drive at negedge, check handshake/output, step model.
  task automatic cycle(input logic v, input logic [32:0] w, input logic ordy,
                       input logic eclr, input logic pclr);
    logic exp_rdy, pres, in_x, out_x;
    in_valid = v; in_word = w; out_ready = ordy; err_clr = eclr; pk_clr = pclr;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    pres = front_presented();
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(pres));
    if (pres) begin
      check("out_level", 32'(out_level), q[0].level);
      check("out_bubble", 32'(out_bubble), q[0].bubble);
    end
    in_x = v && exp_rdy;
    out_x = pres && ordy;
    if (pclr) m_pk = out_x ? q[0].level : 0;
    else if (out_x && q[0].level > m_pk) m_pk = q[0].level;
    if (eclr) m_err = 0;
    else if (in_x && ref_bubble(w) == 1 && m_err < 255) m_err++;
    if (out_x) void'(q.pop_front());
    if (in_x) q.push_back('{ref_level(w), ref_bubble(w), cyc});
    last_acc = in_x;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("err_cnt", 32'(err_cnt), m_err);
    check("pk_level", 32'(pk_level), m_pk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; pk_clr = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_err = 0;
    m_pk = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_level", 32'(out_level), 32'd0);
    check("rst_out_bubble", 32'(out_bubble), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_pk_level", 32'(pk_level), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) cycle(1'b0, 33'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [32:0] w;
    int n;
    int guard;
    @(negedge clk);
    do_reset();
    do_reset();

    // Basic levels and throughput
    cycle(1'b1, 33'h000000001, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 33'h1FFFFFFFF, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 33'h00000001C, 1'b1, 1'b0, 1'b0);
    drain();
    check("peak_all_ones", 32'(pk_level), 32'(LEVEL_MAX));

    // Single bubble word
    cycle(1'b1, 33'h000000014, 1'b1, 1'b0, 1'b0);
    drain();
    check("bubble_err_one", 32'(err_cnt), 32'd1);

    // Stall: two words buffered, third refused
    cycle(1'b1, 33'h00000000D, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 33'h00000003E, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 33'h0000000FF, 1'b0, 1'b0, 1'b0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    guard = 0;
    do begin
      cycle(1'b1, 33'h0000000FF, 1'b1, 1'b0, 1'b0);
      guard++;
    end while (!last_acc && guard < 8);
    check("stall_release_accept", 32'(last_acc), 32'd1);
    drain();

    // Counter saturation and clear-wins
    for (int i = 0; i < 300; i++) cycle(1'b1, 33'h000000014, 1'b1, 1'b0, 1'b0);
    drain();
    check("err_saturate", 32'(err_cnt), 32'd255);
    cycle(1'b1, 33'h000000014, 1'b1, 1'b1, 1'b0);
    check("err_clr_wins", 32'(err_cnt), 32'd0);
    drain();

    // Peak clear during and without a transfer
    cycle(1'b1, 33'h1FFFFFFFF, 1'b1, 1'b0, 1'b0);
    drain();
    cycle(1'b1, 33'h000000005, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (!front_presented() && guard < 8) begin
      cycle(1'b0, 33'd0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    cycle(1'b0, 33'd0, 1'b1, 1'b0, 1'b1);
    check("pk_clr_xfer", 32'(pk_level), 32'd5);
    cycle(1'b0, 33'd0, 1'b1, 1'b0, 1'b1);
    check("pk_clr_idle", 32'(pk_level), 32'd0);

    // Reset with words in flight
    cycle(1'b1, 33'h1FFFFFFFF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 33'h000000017, 1'b0, 1'b0, 1'b0);
    do_reset();
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = int'($urandom_range(0, 31));
        w = 33'd0;
        for (int k = 0; k < n; k++) w[2+k] = 1'b1;
        w[1:0] = 2'($urandom_range(0, 3));
      end else begin
        w[31:0] = $urandom;
        w[32] = 1'($urandom_range(0, 1));
      end
      cycle(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 31) == 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
